// File: rtl/multififo_pop_stage_if.sv
// Bus bundle between the FIFO read ports, the pop stage and downstream.
// slave = pop stage side, master = environment (FIFO + downstream).
interface multififo_pop_stage_if #(
    parameter int PORT_NUM = 2,
    parameter int WIDTH    = 32
);
    localparam int CW = $clog2(PORT_NUM) + 1;

    logic [WIDTH-1:0] fifo_data_out [0:PORT_NUM-1];
    logic [PORT_NUM-1:0] fifo_data_out_valid;
    logic                fifo_empty;
    logic [PORT_NUM-1:0] fifo_data_pop_valid;
    logic                fifo_pop;
    logic [WIDTH-1:0] out_data [0:PORT_NUM-1];
    logic [PORT_NUM-1:0] out_valid;
    logic [CW-1:0]       out_accept_num;

    modport slave (
        input  fifo_data_out,
        input  fifo_data_out_valid,
        input  fifo_empty,
        input  out_accept_num,
        output fifo_data_pop_valid,
        output fifo_pop,
        output out_data,
        output out_valid
    );

    modport master (
        output fifo_data_out,
        output fifo_data_out_valid,
        output fifo_empty,
        output out_accept_num,
        input  fifo_data_pop_valid,
        input  fifo_pop,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/multififo_pop_stage.sv
// Compacting staging register draining multi-port FIFO read slots
// and handing an in-order prefix to downstream each cycle.
module multififo_pop_stage #(
    parameter int PORT_NUM = 2,
    parameter int WIDTH    = 32
) (
    input logic clk,
    input logic rst,
    input logic flush,
    multififo_pop_stage_if.slave bus
);
    localparam int CW = $clog2(PORT_NUM) + 1;
    localparam int AW = $clog2(PORT_NUM);

    logic [WIDTH-1:0] stage_q [0:PORT_NUM-1];
    logic [WIDTH-1:0] stage_d [0:PORT_NUM-1];
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic [CW-1:0] acc;
    logic [CW-1:0] keep;
    logic [CW-1:0] free;
    logic [CW-1:0] avail;
    logic [CW-1:0] take;
    logic [PORT_NUM-1:0] pop_valid;

    always_comb begin
        acc = bus.out_accept_num;
        if (acc > cnt_q) acc = cnt_q;
        keep = cnt_q - acc;
        free = CW'(PORT_NUM) - keep;

        avail = '0;
        if (!bus.fifo_empty) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                avail = avail + CW'(bus.fifo_data_out_valid[i]);
            end
        end

        take = (avail < free) ? avail : free;
        if (rst || flush) take = '0;

        pop_valid = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            pop_valid[i] = (CW'(i) < take);
        end

        // Survivors shift down by acc; fresh entries pack in behind them.
        stage_d = stage_q;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (CW'(k) < keep) begin
                stage_d[k] = stage_q[AW'(CW'(k) + acc)];
            end else if ((CW'(k) - keep) < take) begin
                stage_d[k] = bus.fifo_data_out[AW'(CW'(k) - keep)];
            end
        end

        cnt_d = keep + take;
        if (flush) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        stage_q <= stage_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (bus.out_accept_num <= cnt_q)
            else $warning("over-accept %0d > %0d clamped",
                          bus.out_accept_num, cnt_q);
        end
    end

    always_comb begin
        bus.out_valid = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            bus.out_valid[i] = (CW'(i) < cnt_q);
        end
    end

    assign bus.out_data            = stage_q;
    assign bus.fifo_data_pop_valid = pop_valid;
    assign bus.fifo_pop            = |pop_valid;
endmodule

// File: tb/tb_multififo_pop_stage.sv
// Directed vector bench for multififo_pop_stage with a queue-based
// FIFO model feeding the read ports.
module tb_multififo_pop_stage;
    localparam int P = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    multififo_pop_stage_if #(.PORT_NUM(P), .WIDTH(W)) bus ();

    multififo_pop_stage #(.PORT_NUM(P), .WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic [2:0]  acc;
        int          push_n;
        logic [31:0] push_base;
        logic [3:0]  pv;
        logic [3:0]  ov;
        logic [31:0] d [4];
    } vec_t;

    logic [31:0] q [$];
    int n_run  = 0;
    int n_fail = 0;
    vec_t tbl [$];

    function automatic vec_t mk(
        logic r, logic f, logic [2:0] a,
        int pn, logic [31:0] pb,
        logic [3:0] pv, logic [3:0] ov,
        logic [31:0] d0, logic [31:0] d1,
        logic [31:0] d2, logic [31:0] d3
    );
        vec_t v;
        v.rst = r; v.flush = f; v.acc = a;
        v.push_n = pn; v.push_base = pb;
        v.pv = pv; v.ov = ov;
        v.d[0] = d0; v.d[1] = d1;
        v.d[2] = d2; v.d[3] = d3;
        return v;
    endfunction

    task automatic drive_fifo();
        for (int i = 0; i < P; i++) begin
            if (i < q.size()) begin
                bus.fifo_data_out[i] = q[i];
                bus.fifo_data_out_valid[i] = 1'b1;
            end else begin
                bus.fifo_data_out[i] = '0;
                bus.fifo_data_out_valid[i] = 1'b0;
            end
        end
        bus.fifo_empty = (q.size() == 0);
    endtask

    task automatic chk(string nm, int row,
                       logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h want %h",
                     nm, row, act, exp);
        end
    endtask

    task automatic cyc(vec_t v, int row);
        int n;
        for (int i = 0; i < v.push_n; i++) begin
            q.push_back(v.push_base + 32'(i));
        end
        rst   = v.rst;
        flush = v.flush;
        bus.out_accept_num = v.acc;
        drive_fifo();
        #1;
        chk("pop_valid", row, 32'(bus.fifo_data_pop_valid), 32'(v.pv));
        chk("pop", row, 32'(bus.fifo_pop), 32'(|v.pv));
        chk("out_valid", row, 32'(bus.out_valid), 32'(v.ov));
        for (int k = 0; k < P; k++) begin
            if (v.ov[k]) chk($sformatf("out_data%0d", k), row,
                             bus.out_data[k], v.d[k]);
        end
        n = $countones(bus.fifo_data_pop_valid);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (q.size() != 0) void'(q.pop_front());
        end
        if (v.flush) q.delete();
    endtask

    initial begin
        // reset hold with 8 entries waiting
        tbl.push_back(mk(1, 0, 0, 8, 'h10, 4'h0, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0));
        // backpressure for 5 cycles, staging full
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'hF,
                             'h10, 'h11, 'h12, 'h13));
        end
        tbl.push_back(mk(0, 0, 4, 0, 0, 4'hF, 4'hF,
                         'h10, 'h11, 'h12, 'h13));
        tbl.push_back(mk(0, 0, 4, 0, 0, 4'h0, 4'hF,
                         'h14, 'h15, 'h16, 'h17));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        // full-rate stream of 12
        tbl.push_back(mk(0, 0, 0, 12, 'h100, 4'hF, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4, 0, 0, 4'hF, 4'hF,
                         'h100, 'h101, 'h102, 'h103));
        tbl.push_back(mk(0, 0, 4, 0, 0, 4'hF, 4'hF,
                         'h104, 'h105, 'h106, 'h107));
        tbl.push_back(mk(0, 0, 4, 0, 0, 4'h0, 4'hF,
                         'h108, 'h109, 'h10A, 'h10B));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
        // partial accepts
        tbl.push_back(mk(0, 0, 0, 4, 'hA0, 4'hF, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, 'hA4, 4'h1, 4'hF,
                         'hA0, 'hA1, 'hA2, 'hA3));
        tbl.push_back(mk(0, 0, 2, 0, 0, 4'h1, 4'hF,
                         'hA1, 'hA2, 'hA3, 'hA4));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0, 4'h7,
                         'hA3, 'hA4, 'hA5, 0));
        // over-accept: cnt=2, accept=4
        tbl.push_back(mk(0, 0, 4, 1, 'hB0, 4'h1, 4'h3,
                         'hA4, 'hA5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h1, 'hB0, 0, 0, 0));
        // flush mid-stream
        tbl.push_back(mk(0, 0, 0, 4, 'hC0, 4'h7, 4'h1, 'hB0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3, 'hC4, 4'h0, 4'hF,
                         'hB0, 'hC0, 'hC1, 'hC2));
        tbl.push_back(mk(0, 0, 0, 1, 'h200, 4'h1, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0, 4'h1, 'h200, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0));

        rst = 1'b1;
        flush = 1'b0;
        bus.out_accept_num = '0;
        drive_fifo();
        @(posedge clk);
        #1;

        for (int r = 0; r < tbl.size(); r++) begin
            cyc(tbl[r], r);
        end

        // rst and flush together mid-stream, accept ignored
        cyc(mk(0, 0, 0, 4, 'h300, 4'hF, 4'h0, 0, 0, 0, 0), 100);
        cyc(mk(1, 1, 3, 0, 0, 4'h0, 4'hF,
               'h300, 'h301, 'h302, 'h303), 101);
        cyc(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0), 102);

        // refill behind a partial accept in one edge
        cyc(mk(0, 0, 0, 6, 'h400, 4'hF, 4'h0, 0, 0, 0, 0), 103);
        cyc(mk(0, 0, 3, 0, 0, 4'h3, 4'hF,
               'h400, 'h401, 'h402, 'h403), 104);
        cyc(mk(0, 0, 3, 0, 0, 4'h0, 4'h7,
               'h403, 'h404, 'h405, 0), 105);
        cyc(mk(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0), 106);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
